// File: rtl/blur_frame_ctrl.sv
// Frame sequencer for the gaussian_blur core: streams one frame from the input memory into the
// core and captures its results. Optional macro BLUR_CTRL_FRAME_CNT_EN adds a clean-frame counter.
module blur_frame_ctrl #(
    parameter int  IMG_W         = 32,
    parameter int  IMG_H         = 24,
    parameter int  DRAIN_TIMEOUT = 16,
    parameter int  DATA_W        = 8,
    localparam int NUM_PIXELS    = IMG_W * IMG_H,
    localparam int ADDR_W        = $clog2(NUM_PIXELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rd_data,
    output logic [DATA_W-1:0] blur_pixel_in,
    output logic              blur_pixel_vld,
    input  logic [DATA_W-1:0] blur_pixel_out,
    input  logic              blur_pixel_vld_out,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [DATA_W-1:0] out_wr_data,
`ifdef BLUR_CTRL_FRAME_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    output logic [ADDR_W:0]   out_count
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int SIL_W = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_vld_p1;
    logic              wr_en_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [DATA_W-1:0] wr_data_p1;
    logic [CNT_W-1:0]  cnt;
    logic [SIL_W-1:0]  silence;
    logic              done_q;
    logic              err_q;

    logic              issue;
    logic              capture;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              frame_full;
    logic              drain_expired;

    // silence holds the number of cycles since the last core output (or since the last read),
    // so the frame aborts with done landing exactly DRAIN_TIMEOUT cycles after that event.
    always_comb begin
        issue         = (state == S_FEED) && !pause;
        capture       = blur_pixel_vld_out && (state != S_IDLE) && (cnt < CNT_W'(NUM_PIXELS));
        cnt_nxt       = cnt + CNT_W'(capture);
        frame_full    = (state == S_DRAIN) && (cnt_nxt == CNT_W'(NUM_PIXELS));
        drain_expired = (state == S_DRAIN) && !blur_pixel_vld_out &&
                        (silence == SIL_W'(DRAIN_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            rd_vld_p1  <= 1'b0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            cnt        <= '0;
            silence    <= SIL_W'(1);
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // p1: read data returns, capture of core output is registered
            rd_vld_p1 <= issue;
            wr_en_p1  <= capture;
            done_q    <= 1'b0;
            cnt       <= cnt_nxt;
            if (capture) begin
                wr_addr_p1 <= cnt[ADDR_W-1:0];
                wr_data_p1 <= blur_pixel_out;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FEED;
                        rd_addr <= '0;
                        cnt     <= '0;
                        err_q   <= 1'b0;
                        silence <= SIL_W'(1);
                    end
                end
                S_FEED: begin
                    silence <= SIL_W'(1);
                    if (issue) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (rd_addr == ADDR_W'(NUM_PIXELS - 1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    silence <= blur_pixel_vld_out ? SIL_W'(1) : silence + SIL_W'(1);
                    if (frame_full) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end else if (drain_expired) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BLUR_CTRL_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_full) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    assign busy           = (state != S_IDLE);
    assign done           = done_q;
    assign timeout_err    = err_q;
    assign in_rd_en       = issue;
    assign in_rd_addr     = rd_addr;
    // Gating keeps stale memory data off the core bus between valid beats.
    assign blur_pixel_vld = rd_vld_p1;
    assign blur_pixel_in  = rd_vld_p1 ? in_rd_data : '0;
    assign out_wr_en      = wr_en_p1;
    assign out_wr_addr    = wr_addr_p1;
    assign out_wr_data    = wr_data_p1;
    assign out_count      = cnt;

endmodule

// File: tb/tb_blur_frame_ctrl.sv
// Scoreboard bench for blur_frame_ctrl with a pixel memory model and a latency-configurable core model.
module tb_blur_frame_ctrl;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 24;
    localparam int DTO    = 16;
    localparam int NUM    = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(NUM);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              pause = 1'b0;
    logic              busy, done, timeout_err, in_rd_en, blur_pixel_vld, out_wr_en;
    logic [ADDR_W-1:0] in_rd_addr, out_wr_addr;
    logic [7:0]        in_rd_data = 8'd0;
    logic [7:0]        blur_pixel_in, out_wr_data;
    logic [7:0]        blur_pixel_out = 8'd0;
    logic              blur_pixel_vld_out = 1'b0;
    logic [ADDR_W:0]   out_count;
`ifdef BLUR_CTRL_FRAME_CNT_EN
    logic [15:0]       frame_cnt;
`endif

    blur_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DRAIN_TIMEOUT(DTO), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .busy(busy), .done(done),
        .timeout_err(timeout_err), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .in_rd_data(in_rd_data), .blur_pixel_in(blur_pixel_in), .blur_pixel_vld(blur_pixel_vld),
        .blur_pixel_out(blur_pixel_out), .blur_pixel_vld_out(blur_pixel_vld_out),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
`ifdef BLUR_CTRL_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name, input longint act);
        n_checks++;
        $display("FAIL %s: got %0d, required no such event", name, act);
    endtask

    // Abstract core behaviour: each accepted pixel p comes back as 3p+7 after a fixed latency.
    function automatic logic [7:0] core_f(input logic [7:0] p);
        return 8'(p * 3 + 7);
    endfunction

    logic [7:0] mem [NUM];
    always @(posedge clk) if (in_rd_en) in_rd_data <= mem[in_rd_addr];

    typedef struct { int due; logic [7:0] d; } core_item_t;
    core_item_t core_q[$];
    int core_acc   = 0;
    int core_lat   = 3;
    int core_limit = NUM;

    always @(posedge clk) begin
        if (blur_pixel_vld && core_acc < core_limit) begin
            core_q.push_back('{due: cyc + core_lat, d: core_f(blur_pixel_in)});
            core_acc <= core_acc + 1;
        end else if (!busy && !blur_pixel_vld) begin
            core_acc <= 0;
        end
        if (core_q.size() > 0 && core_q[0].due == cyc + 1) begin
            blur_pixel_vld_out <= 1'b1;
            blur_pixel_out     <= core_q[0].d;
            void'(core_q.pop_front());
        end else begin
            blur_pixel_vld_out <= 1'b0;
        end
    end

    typedef struct { int addr; logic [7:0] d; } wr_t;
    wr_t        exp_wr[$];
    logic [7:0] exp_in[$];
    int         exp_rd[$];
    int         n_done = 0;
    int         last_out_cyc = -1;
    int         last_rd_cyc = -1;
    wr_t        w;

    always @(negedge clk) begin
        if (in_rd_en) begin
            if (exp_rd.size() == 0) fail_now("rd_unexpected", in_rd_addr);
            else check("rd_addr", in_rd_addr, exp_rd.pop_front());
            last_rd_cyc = cyc;
        end
        if (blur_pixel_vld) begin
            if (exp_in.size() == 0) fail_now("core_in_unexpected", blur_pixel_in);
            else check("core_in_data", blur_pixel_in, exp_in.pop_front());
        end
        if (out_wr_en) begin
            if (exp_wr.size() == 0) fail_now("wr_unexpected", out_wr_addr);
            else begin
                w = exp_wr.pop_front();
                check("wr_addr", out_wr_addr, w.addr);
                check("wr_data", out_wr_data, w.d);
            end
        end
        if (blur_pixel_vld_out) last_out_cyc = cyc;
        if (done) n_done++;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_in_rd_en"}, in_rd_en, 0);
        check({tag, "_in_rd_addr"}, in_rd_addr, 0);
        check({tag, "_pixel_vld"}, blur_pixel_vld, 0);
        check({tag, "_pixel_in"}, blur_pixel_in, 0);
        check({tag, "_out_wr_en"}, out_wr_en, 0);
        check({tag, "_out_wr_addr"}, out_wr_addr, 0);
        check({tag, "_out_wr_data"}, out_wr_data, 0);
        check({tag, "_out_count"}, out_count, 0);
    endtask

    task automatic start_frame(input bit rnd, input int lat, input int limit, input int at_cyc,
                               output int t0);
        do begin @(posedge clk); #1; end while (cyc < at_cyc);
        exp_wr.delete(); exp_in.delete(); exp_rd.delete();
        for (int i = 0; i < NUM; i++) begin
            mem[i] = rnd ? 8'($urandom) : 8'(i);
            exp_rd.push_back(i);
            exp_in.push_back(mem[i]);
            if (i < limit) exp_wr.push_back('{addr: i, d: core_f(mem[i])});
        end
        core_lat   = lat;
        core_limit = limit;
        start = 1'b1;
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic end_frame(input int exp_cnt, input bit exp_err, input string tag);
        int nd0;
        int n;
        bit got;
        nd0 = n_done;
        n   = 0;
        got = 0;
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
        end
        if (!got) begin
            fail_now({tag, "_done_never_seen"}, n);
        end else begin
            check({tag, "_busy_at_done"}, busy, 0);
            check({tag, "_out_count"}, out_count, exp_cnt);
            check({tag, "_timeout_err"}, timeout_err, exp_err);
            check({tag, "_done_gap"}, cyc - last_out_cyc, exp_err ? DTO : 1);
        end
        #1;
        check({tag, "_writes_left"}, exp_wr.size(), 0);
        check({tag, "_inputs_left"}, exp_in.size() + exp_rd.size(), 0);
        check({tag, "_done_pulses"}, n_done - nd0, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    int  t0;
    bit  pause_run;
    int  n;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame A: ramp, start at cycle 10, stray start mid-FEED.
        start_frame(1'b0, 3, NUM, 10, t0);
        @(negedge clk);
        check("lat_busy", busy, 1);
        check("lat_rd_en", in_rd_en, 1);
        check("lat_rd_addr0", in_rd_addr, 0);
        check("lat_vld_not_yet", blur_pixel_vld, 0);
        @(negedge clk);
        check("lat_vld_first", blur_pixel_vld, 1);
        check("lat_rd_addr1", in_rd_addr, 1);
        while (cyc < t0 + 200) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        end_frame(NUM, 1'b0, "frameA");
        check("last_read_latency", last_rd_cyc - t0, NUM);

        // Frame B: 5-cycle pause after address 100.
        start_frame(1'b1, int'($urandom_range(1, 8)), NUM, 0, t0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(in_rd_en && in_rd_addr == 100) && n < 400);
        check("pause_reach_addr100", (in_rd_en && in_rd_addr == 100), 1);
        @(posedge clk); #1;
        pause = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("pause_no_read", in_rd_en, 0);
            check("pause_vld_gap", blur_pixel_vld, (j == 0));
        end
        @(posedge clk); #1;
        pause = 1'b0;
        @(negedge clk);
        check("pause_resume_en", in_rd_en, 1);
        check("pause_resume_addr", in_rd_addr, 101);
        check("pause_resume_vld_gap", blur_pixel_vld, 0);
        end_frame(NUM, 1'b0, "frameB");
`ifdef BLUR_CTRL_FRAME_CNT_EN
        check("frame_cnt_two", frame_cnt, 2);
`endif

        // Frame C: random pause pattern throughout.
        start_frame(1'b1, int'($urandom_range(1, 8)), NUM, 0, t0);
        pause_run = 1'b1;
        fork
            begin
                while (pause_run) begin
                    @(posedge clk); #1;
                    pause = ($urandom_range(0, 3) == 0);
                end
                pause = 1'b0;
            end
            begin
                end_frame(NUM, 1'b0, "frameC");
                pause_run = 1'b0;
            end
        join

        // Frame D: core goes silent after 700 outputs.
        start_frame(1'b1, 80, 700, 0, t0);
        end_frame(700, 1'b1, "frameD");
`ifdef BLUR_CTRL_FRAME_CNT_EN
        check("frame_cnt_after_timeout", frame_cnt, 3);
`endif

        // Frame E: timeout_err clears on start, then reset mid-frame.
        start_frame(1'b1, 3, NUM, 0, t0);
        @(negedge clk);
        check("err_cleared_by_start", timeout_err, 0);
        check("frameE_busy", busy, 1);
        while (cyc < t0 + 300) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_wr.delete(); exp_in.delete(); exp_rd.delete();
        @(negedge clk);
        check_all_zero("rst_mid");
`ifdef BLUR_CTRL_FRAME_CNT_EN
        check("rst_mid_frame_cnt", frame_cnt, 0);
`endif
        repeat (10) @(posedge clk);

        // Frame F: fresh frame after reset.
        start_frame(1'b1, 3, NUM, 0, t0);
        end_frame(NUM, 1'b0, "frameF");
`ifdef BLUR_CTRL_FRAME_CNT_EN
        check("frame_cnt_after_rst_frame", frame_cnt, 1);
`endif

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/blur_frame_ctrl.md
# blur_frame_ctrl

Frame sequencer for the `gaussian_blur` core. On `start`, it reads one IMG_W×IMG_H 8-bit frame from an input pixel memory and streams it into the core's `pixel_in`/`pixel_vld`. It captures every `pixel_vld_out` result into an output pixel memory and signals completion. It sits between the frame buffers and the blur datapath, replacing bench-driven streaming in the accelerator top.

## Interface
Parameters and derived constants:
- `IMG_W`, 32, frame width in pixels.
- `IMG_H`, 24, frame height in pixels.
- `DRAIN_TIMEOUT`, 16, idle cycles without a core output (after the last input) before the frame is aborted.
- Derived (localparam): `NUM_PIXELS = IMG_W*IMG_H`, `ADDR_W = $clog2(NUM_PIXELS)`.

Ports (reset is synchronous, active-high):
- `clk` input 1: single clock.
- `rst` input 1: synchronous active-high reset.
- `start` input 1: single-cycle frame request; honoured only in IDLE.
- `pause` input 1: while high, no new input read is issued.
- `busy` output 1: high in FEED and DRAIN.
- `done` output 1: one-cycle pulse at frame end.
- `timeout_err` output 1: sticky; set on drain timeout; cleared by the next accepted `start` or by `rst`.
- `in_rd_en` output 1: input memory read strobe.
- `in_rd_addr` output ADDR_W: input read address.
- `in_rd_data` input 8: read data, valid exactly 1 cycle after `in_rd_en`.
- `blur_pixel_in` output 8: to core `pixel_in`.
- `blur_pixel_vld` output 1: to core `pixel_vld`.
- `blur_pixel_out` input 8: from core `pixel_out`.
- `blur_pixel_vld_out` input 1: from core `pixel_vld_out`.
- `out_wr_en` output 1: output memory write strobe.
- `out_wr_addr` output ADDR_W: output write address.
- `out_wr_data` output 8: output write data.
- `out_count` output ADDR_W+1: outputs captured in the current/last frame.

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE → FEED on `start`:
  - Read address and `out_count` clear to 0.
  - `timeout_err` clears.
- FEED, each cycle with `pause`=0:
  - Assert `in_rd_en` at the current address, then increment the address.
  - After issuing address NUM_PIXELS-1, go to DRAIN.
  - `pause`=1 inserts bubbles only; no read is issued and the address holds.
- Core input:
  - `blur_pixel_vld` = `in_rd_en` delayed 1 cycle.
  - `blur_pixel_in` = `in_rd_data` in that same cycle.
  - The core never receives valid with stale data.
- Output capture (FEED or DRAIN):
  - Each `blur_pixel_vld_out` with `out_count` < NUM_PIXELS produces one registered write at `out_wr_addr` = `out_count`, then `out_count` increments.
  - `blur_pixel_vld_out` while `out_count` == NUM_PIXELS, or while in IDLE, is ignored: no write, no count.
- DRAIN:
  - A silence counter resets on every `blur_pixel_vld_out` and increments otherwise.
  - Normal exit: `out_count` reaches NUM_PIXELS → `done` pulse, go to IDLE.
  - Timeout exit: silence counter reaches DRAIN_TIMEOUT → `timeout_err`=1, `done` pulse, go to IDLE.
  - Normal completion has priority over timeout in the same cycle.
- `start` while busy is ignored. `pause` in DRAIN/IDLE has no effect.
- `rst` at any time, including mid-frame:
  - All outputs go to 0 next cycle; state goes to IDLE.
  - Pending pipelined reads are discarded.

## Timing
- Reset values: `busy`, `done`, `timeout_err`, `in_rd_en`, `blur_pixel_vld`, `out_wr_en` = 0; all addresses, data and `out_count` = 0.
- Start latency:
  - `start` at cycle T → `busy` and first `in_rd_en` (addr 0) at T+1.
  - First `blur_pixel_vld` at T+2.
- Input throughput: unpaused FEED issues one read per cycle; the last read is at T+NUM_PIXELS.
- Capture latency: `blur_pixel_vld_out` at cycle C → `out_wr_en` at C+1.
- Completion:
  - `done` is asserted the cycle after the write of the last pixel is issued, i.e. the cycle `out_count` reads NUM_PIXELS.
  - `busy` drops in that same cycle.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- Macro: `BLUR_CTRL_FRAME_CNT_EN`.
- Defined:
  - Adds output `frame_cnt` [15:0], reset 0.
  - Increments on every `done` with `timeout_err`=0; wraps 0xFFFF→0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Nominal frame: ramp input (`mem[i]=i[7:0]`); core model with 3-cycle latency, one output per input.
  - Expect 768 writes, addresses 0..767; `done` once; `out_count`=768; `timeout_err`=0.
- Start latency: `start` at cycle 10.
  - Expect `in_rd_en`/addr 0 at 11, `blur_pixel_vld` at 12, last read (addr 767) at 778.
- Pause: hold `pause`=1 for 5 cycles after addr 100.
  - Expect no reads for those 5 cycles, resume at addr 101.
  - `blur_pixel_vld` shows an identical 5-cycle gap; no duplicate or dropped pixel.
- Timeout: core model stops after 700 outputs.
  - Expect `done` with `timeout_err`=1 exactly 16 cycles after the last output; `out_count`=700.
- Robustness:
  - `start` mid-FEED is ignored.
  - `rst` at cycle 300 → all outputs 0 next cycle.
  - A fresh `start` then completes normally.
  - With `BLUR_CTRL_FRAME_CNT_EN`: `frame_cnt` = 2 after two clean frames, unchanged after a timeout frame.
